// File: rtl/encrypt.sv
// Iterative 64-bit nibble-oriented block cipher: one round per clock, four rounds per block.
// Optional ENCRYPT_LASTKEY_EN adds a lastKey output holding the final round key.
module encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] plaintext,
    input  logic [63:0] secretKey,
    output logic [63:0] ciphertext,
    output logic        busy,
    output logic        done
`ifdef ENCRYPT_LASTKEY_EN
    ,
    output logic [63:0] lastKey
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [63:0] key_q, key_d;
    logic [1:0]  round_q, round_d;
    logic [63:0] ct_q, ct_d;
    logic        done_q, done_d;
`ifdef ENCRYPT_LASTKEY_EN
    logic [63:0] lastkey_q, lastkey_d;
`endif

    logic [3:0]  rcon;
    logic [63:0] next_key;
    logic [63:0] shifted;
    logic [63:0] round_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h9;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'hB;
            4'h4: y = 4'hD;
            4'h5: y = 4'h1;
            4'h6: y = 4'h8;
            4'h7: y = 4'h5;
            4'h8: y = 4'h6;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'h3;
            4'hC: y = 4'hC;
            4'hD: y = 4'hE;
            4'hE: y = 4'hF;
            default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sub_nibbles(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Nibble (row r, column c) sits at bits [63-4*(4c+r) -: 4].
    function automatic logic [63:0] shift_rows(input logic [63:0] x);
        logic [63:0] y;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[63-4*(4*c+r) -: 4] = x[63-4*(4*((c+r)%4)+r) -: 4];
            end
        end
        return y;
    endfunction

    // Multiply by x in GF(2^4) modulo x^4+x+1.
    function automatic logic [3:0] gf_x2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    function automatic logic [3:0] gf_x3(input logic [3:0] a);
        return gf_x2(a) ^ a;
    endfunction

    function automatic logic [63:0] mix_columns(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[63-16*c -: 4];
            a1 = x[59-16*c -: 4];
            a2 = x[55-16*c -: 4];
            a3 = x[51-16*c -: 4];
            y[63-16*c -: 4] = gf_x2(a0) ^ gf_x3(a1) ^ a2 ^ a3;
            y[59-16*c -: 4] = a0 ^ gf_x2(a1) ^ gf_x3(a2) ^ a3;
            y[55-16*c -: 4] = a0 ^ a1 ^ gf_x2(a2) ^ gf_x3(a3);
            y[51-16*c -: 4] = gf_x3(a0) ^ a1 ^ a2 ^ gf_x2(a3);
        end
        return y;
    endfunction

    function automatic logic [63:0] key_expand(input logic [63:0] k, input logic [3:0] rc);
        logic [15:0] w0, w1, w2, w3, rot, t;
        w0  = k[63:48];
        w1  = k[47:32];
        w2  = k[31:16];
        w3  = k[15:0];
        rot = {w3[11:0], w3[15:12]};
        t   = {sbox(rot[15:12]) ^ rc, sbox(rot[11:8]), sbox(rot[7:4]), sbox(rot[3:0])};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round datapath: round_q counts completed rounds, so rcon = 1,2,4,8.
    always_comb begin
        rcon      = 4'b0001 << round_q;
        next_key  = key_expand(key_q, rcon);
        shifted   = shift_rows(sub_nibbles(data_q));
        round_out = ((round_q == 2'd3) ? shifted : mix_columns(shifted)) ^ next_key;
    end

    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        round_d = round_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
`ifdef ENCRYPT_LASTKEY_EN
        lastkey_d = lastkey_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = plaintext ^ secretKey;
                    key_d   = secretKey;
                    round_d = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d  = round_out;
                key_d   = next_key;
                round_d = round_q + 2'd1;
                if (round_q == 2'd3) begin
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef ENCRYPT_LASTKEY_EN
                    lastkey_d = next_key;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
`ifdef ENCRYPT_LASTKEY_EN
            lastkey_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
`ifdef ENCRYPT_LASTKEY_EN
            lastkey_q <= lastkey_d;
`endif
        end
    end

    assign ciphertext = ct_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
`ifdef ENCRYPT_LASTKEY_EN
    assign lastKey    = lastkey_q;
`endif

endmodule

// File: tb/tb_encrypt.sv
// Directed self-checking bench for encrypt; golden values come from a nibble-array reference model.
// Define ENCRYPT_LASTKEY_EN for both files to exercise the lastKey output.
module tb_encrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] plaintext;
    logic [63:0] secretKey;
    logic [63:0] ciphertext;
    logic        busy;
    logic        done;
`ifdef ENCRYPT_LASTKEY_EN
    logic [63:0] lastKey;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] sbox_t [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
    logic [3:0] mc_t [16]   = '{4'h2, 4'h3, 4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h1,
                                4'h1, 4'h1, 4'h2, 4'h3, 4'h3, 4'h1, 4'h1, 4'h2};

    encrypt dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .secretKey  (secretKey),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
`ifdef ENCRYPT_LASTKEY_EN
        ,
        .lastKey    (lastKey)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Shift-and-add multiply with reduction by x^4+x+1 (0x13).
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) if (b[i]) p ^= 8'(a) << i;
        for (int i = 7; i >= 4; i--) if (p[i]) p ^= 8'h13 << (i - 4);
        return p[3:0];
    endfunction

    task automatic model(input logic [63:0] pt, input logic [63:0] key,
                         output logic [63:0] ct, output logic [63:0] k4);
        logic [3:0]  s [16];
        logic [3:0]  t [16];
        logic [15:0] w [4];
        logic [15:0] tw;
        logic [63:0] kv;
        logic [3:0]  acc;
        kv = key;
        for (int n = 0; n < 16; n++) s[n] = pt[63-4*n -: 4] ^ kv[63-4*n -: 4];
        for (int rnd = 1; rnd <= 4; rnd++) begin
            w[0] = kv[63:48];
            w[1] = kv[47:32];
            w[2] = kv[31:16];
            w[3] = kv[15:0];
            tw = {w[3][11:0], w[3][15:12]};
            for (int j = 0; j < 4; j++) tw[4*j +: 4] = sbox_t[tw[4*j +: 4]];
            tw[15:12] ^= 4'(1 << (rnd - 1));
            w[0] ^= tw;
            w[1] ^= w[0];
            w[2] ^= w[1];
            w[3] ^= w[2];
            kv = {w[0], w[1], w[2], w[3]};
            for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 4) begin
                        acc = 4'h0;
                        for (int k = 0; k < 4; k++) acc ^= gmul(mc_t[4*r+k], t[k+4*c]);
                        s[r+4*c] = acc;
                    end else begin
                        s[r+4*c] = t[r+4*c];
                    end
                end
            end
            for (int n = 0; n < 16; n++) s[n] ^= kv[63-4*n -: 4];
        end
        for (int n = 0; n < 16; n++) ct[63-4*n -: 4] = s[n];
        k4 = kv;
    endtask

    // One start pulse, then latency and result checks against the model.
    task automatic run_block(input string tag, input logic [63:0] pt, input logic [63:0] key);
        logic [63:0] exp_ct, exp_k4;
        int n;
        model(pt, key, exp_ct, exp_k4);
        plaintext = pt;
        secretKey = key;
        start     = 1'b1;
        step();
        start     = 1'b0;
        plaintext = ~pt;
        secretKey = ~key;
        wait_done(10, n);
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_ct"}, ciphertext, exp_ct);
        step();
        check({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_ct, exp_k4, first_ct;
        int n, dones, last_t, first_t;

        rst       = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        secretKey = '0;
        step();
        step();
        check("rst_ct", ciphertext, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
`ifdef ENCRYPT_LASTKEY_EN
        check("rst_lastkey", lastKey, 64'd0);
`endif
        rst = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Latency: busy for exactly 4 cycles, done on the 4th edge after acceptance.
        model(64'd0, 64'd0, exp_ct, exp_k4);
        plaintext = 64'd0;
        secretKey = 64'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("lat_busy_%0d", i), 64'(busy), 64'd1);
            check($sformatf("lat_nodone_%0d", i), 64'(done), 64'd0);
            if (i < 4) step();
        end
        step();
        check("lat_done", 64'(done), 64'd1);
        check("lat_busy_low", 64'(busy), 64'd0);
        check("lat_ct", ciphertext, exp_ct);
`ifdef ENCRYPT_LASTKEY_EN
        check("lat_lastkey", lastKey, exp_k4);
`endif
        step();
        check("lat_done_pulse", 64'(done), 64'd0);
        check("lat_ct_hold", ciphertext, exp_ct);

        // Known-answer sweep.
        run_block("kat_ff", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        run_block("kat_123", 64'h1234_5678_9ABC_DEF0, 64'h0F1E_2D3C_4B5A_6978);
        run_block("kat_dead", 64'hDEAD_BEEF_CAFE_BABE, 64'h0123_4567_89AB_CDEF);

        // Busy-ignore: a second start two cycles after acceptance must be dropped.
        model(64'hA5A5_0F0F_3C3C_9669, 64'h1357_9BDF_2468_ACE0, exp_ct, exp_k4);
        plaintext = 64'hA5A5_0F0F_3C3C_9669;
        secretKey = 64'h1357_9BDF_2468_ACE0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        plaintext = 64'h0F0F_0F0F_F0F0_F0F0;
        secretKey = 64'hFEDC_BA98_7654_3210;
        start     = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        check("ign_dones", 64'(dones), 64'd1);
        check("ign_ct", ciphertext, exp_ct);
        check("ign_idle", 64'(busy), 64'd0);

        // Streaming: start held high, completions every 5 cycles.
        model(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, exp_ct, exp_k4);
        plaintext = 64'h1111_1111_1111_1111;
        secretKey = 64'h2222_2222_2222_2222;
        start     = 1'b1;
        dones     = 0;
        last_t    = 0;
        first_t   = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (done === 1'b1) begin
                dones++;
                check($sformatf("stream_ct_%0d", dones), ciphertext, exp_ct);
                if (dones == 1) first_t = i;
                else check($sformatf("stream_gap_%0d", dones), 64'(i - last_t), 64'd5);
                last_t = i;
            end
        end
        check("stream_count", 64'(dones), 64'd3);
        check("stream_first", 64'(first_t), 64'd5);
        start = 1'b0;
        wait_done(10, n);
        step();
        first_ct = ciphertext;
        check("stream_ct_nonzero", 64'(first_ct != 64'd0), 64'd1);

        // Reset mid-round: immediate clear, no done pulse afterwards.
        plaintext = 64'hDEAD_BEEF_CAFE_BABE;
        secretKey = 64'h0123_4567_89AB_CDEF;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        check("abort_ct", ciphertext, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_busy_after", 64'(busy), 64'd0);

        // Start presented at reset release is accepted on the first edge.
        model(64'h1234_5678_9ABC_DEF0, 64'h0F1E_2D3C_4B5A_6978, exp_ct, exp_k4);
        rst = 1'b1;
        step();
        plaintext = 64'h1234_5678_9ABC_DEF0;
        secretKey = 64'h0F1E_2D3C_4B5A_6978;
        start     = 1'b1;
        rst       = 1'b0;
        step();
        start = 1'b0;
        check("release_accept", 64'(busy), 64'd1);
        wait_done(10, n);
        check("release_latency", 64'(n), 64'd4);
        check("release_ct", ciphertext, exp_ct);
`ifdef ENCRYPT_LASTKEY_EN
        check("release_lastkey", lastKey, exp_k4);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
